// File: rtl/serial_parity_checker.sv
// Serial parity checker: XOR-folds DATA_BITS data bits into a running accumulator,
// then compares the result against one trailing parity bit.
module serial_parity_checker #(
    parameter int DATA_BITS = 8,
    parameter bit ODD       = 1'b0,
    localparam int CW       = $clog2(DATA_BITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          bit_in,
    input  logic          bit_valid,
    output logic          busy,
    output logic          done,
    output logic          parity_calc,
    output logic          parity_ok,
    output logic [CW-1:0] bit_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic          acc_reg, acc_next;
    logic [CW-1:0] count_reg, count_next;
    logic          ok_reg, ok_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= 1'b0;
            count_reg <= '0;
            ok_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            ok_reg    <= ok_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        ok_next    = ok_reg;

        // abort outranks start and bit_valid in every state
        if (abort) begin
            state_next = IDLE;
            acc_next   = 1'b0;
            count_next = '0;
            ok_next    = 1'b0;
        end else begin
            unique case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_next = DATA;
                        acc_next   = 1'b0;
                        count_next = '0;
                        ok_next    = 1'b0;
                    end else if (state_reg == DONE) begin
                        state_next = IDLE;
                    end
                end
                DATA: begin
                    if (bit_valid) begin
                        acc_next   = acc_reg ^ bit_in;
                        count_next = count_reg + CW'(1);
                        if (count_reg == CW'(DATA_BITS - 1)) begin
                            state_next = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (bit_valid) begin
                        ok_next    = ((acc_reg ^ ODD) == bit_in);
                        state_next = DONE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy        = (state_reg == DATA) || (state_reg == PARITY);
    assign done        = (state_reg == DONE);
    assign parity_calc = acc_reg ^ ODD;
    assign parity_ok   = ok_reg;
    assign bit_count   = count_reg;

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Serial-stream consumer of the two-input XOR stage; folds it into a running accumulator, acc_next = acc ^ bit_in, one bit per accepted cycle.
- Receives a frame of DATA_BITS data bits followed by one parity bit.
- Reports the computed parity and whether the received parity bit matches.
- Sits downstream of the combinational XOR primitives, as the first sequential user of them in the design.

Parameters:
DATA_BITS, 8, data bits per frame (legal range 1..32)
ODD, 0, 0 = even parity (data+parity has an even number of ones), 1 = odd parity

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a frame; sampled only in IDLE or DONE
abort  input  1  synchronous frame cancel; returns FSM to IDLE
bit_in  input  1  serial data/parity bit
bit_valid  input  1  bit_in is valid this cycle
busy  output  1  high in DATA or PARITY
done  output  1  one-cycle pulse when the parity bit is consumed
parity_calc  output  1  expected parity bit = acc ^ ODD; held after done
parity_ok  output  1  parity_calc == received parity bit; valid from done until next start
bit_count  output  $clog2(DATA_BITS+1)  data bits accepted in the current frame

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, acc=0, bit_count=0.
  - busy=0, done=0, parity_calc=ODD, parity_ok=0.
  - Reset mid-frame discards the frame; no done pulse is produced.
- FSM states: IDLE, DATA, PARITY, DONE.
- IDLE:
  - start=1 -> DATA; acc<=0; bit_count<=0; parity_ok<=0.
  - bit_valid is ignored in IDLE.
- DATA:
  - Each cycle with bit_valid=1: acc<=acc^bit_in; bit_count<=bit_count+1.
  - bit_valid=0 stalls; state and count hold.
  - When a valid bit is accepted with bit_count==DATA_BITS-1 -> PARITY; bit_count becomes DATA_BITS.
- PARITY:
  - First cycle with bit_valid=1: parity_ok<=((acc^ODD)==bit_in); state -> DONE; done=1 for that next cycle only.
  - Invalid cycles stall.
- DONE:
  - Lasts one cycle; done=1; outputs hold.
  - start=1 -> DATA (back-to-back frame, counters cleared).
  - start=0 -> IDLE.
  - parity_calc, parity_ok and bit_count hold until the next start is accepted.
- parity_calc: combinational from acc, (acc ^ ODD); tracks acc during the frame.
- start while busy: ignored; it does not restart the frame.
- abort:
  - In any state, abort=1 -> IDLE next cycle; acc=0, bit_count=0, parity_ok=0, no done.
  - abort has priority over start and bit_valid in the same cycle.
- Latency: done asserts exactly 1 cycle after the clock edge that accepts the parity bit.
- Minimum frame time: 1 (start) + DATA_BITS + 1 cycles with bit_valid held high.
- bit_count never exceeds DATA_BITS; no wrap-around.
- DATA_BITS=1: the frame is one data bit then the parity bit; DATA -> PARITY after one accepted bit.
- All outputs are registered except parity_calc.

Test Plan:
- DATA_BITS=8, ODD=0; start, then bits of 0xA5 LSB-first, parity bit 0, continuous valid -> done one cycle after the parity bit; parity_calc=0, parity_ok=1, bit_count=8.
- 0x01, parity bit 0 -> parity_calc=1, parity_ok=0.
  - Rerun with parity bit 1 -> parity_ok=1.
- 0xFF with bit_valid toggled 1/0 every cycle, parity bit 0 -> parity_ok=1.
  - bit_count holds on invalid cycles.
  - done arrives 18 cycles after start.
- Reset and abort:
  - rst_n=0 after 4 data bits -> all outputs at reset values immediately (before the clock edge); no done.
  - Separately, abort with start high in the same cycle -> IDLE.
- Start while busy, and back-to-back frames:
  - start pulsed during DATA at bit 3 -> ignored; frame completes normally.
  - start held in DONE -> second frame 0x03/parity 0 gives parity_ok=1, bit_count cleared to 0 first.
- ODD=1 instance: 0x00, parity bit 1 -> parity_calc=1, parity_ok=1.
  - Parity bit 0 -> parity_ok=0.
